// File: rtl/convert_to_twos_comp.sv
// Sign/magnitude to N-bit two's-complement converter with one registered stage and overflow flag.
// Optional build macro CONVERT_TO_TWOS_COMP_SAT_EN clamps overflowing results instead of wrapping.
module convert_to_twos_comp #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic         signbit,
    output logic         out_valid,
    output logic [N-1:0] converted,
    output logic         ovf
);

    localparam logic [N-1:0] C_ZERO    = {N{1'b0}};
    localparam logic [N-1:0] C_ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] C_MSB     = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] C_POS_MAX = {1'b0, {(N-1){1'b1}}};

    logic [N-1:0] w_neg;
    logic [N-1:0] w_raw;
    logic         w_ovf;
    logic [N-1:0] w_result;

    logic         r_out_valid;
    logic [N-1:0] r_converted;
    logic         r_ovf;

    // Negation, raw selection and overflow detection, all at N bits.
    always_comb begin
        w_neg = (~a) + C_ONE;
        w_raw = C_ZERO;
        w_ovf = 1'b0;
        case (signbit)
            1'b0: begin
                w_raw = a;
                w_ovf = a[N-1];
            end
            1'b1: begin
                w_raw = w_neg;
                // Exactly 2^(N-1) is the most negative value and still fits.
                w_ovf = a[N-1] & (|a[N-2:0]);
            end
            default: begin
                w_raw = C_ZERO;
                w_ovf = 1'b0;
            end
        endcase
    end

    // Overflow handling: clamp to the representable extreme or keep the wrapped value.
    always_comb begin
        w_result = w_raw;
`ifdef CONVERT_TO_TWOS_COMP_SAT_EN
        if (w_ovf) begin
            if (signbit) begin
                w_result = C_MSB;
            end else begin
                w_result = C_POS_MAX;
            end
        end else begin
            w_result = w_raw;
        end
`else
        w_result = w_raw;
`endif
    end

    // Output stage: valid follows in_valid by one clock, data holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_converted <= C_ZERO;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_converted <= w_result;
                r_ovf       <= w_ovf;
            end else begin
                r_converted <= r_converted;
                r_ovf       <= r_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign converted = r_converted;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_convert_to_twos_comp.sv
// Randomized scoreboard bench for convert_to_twos_comp; the reference model uses signed integer arithmetic.
module tb_convert_to_twos_comp;

    localparam int N = 10;

    typedef struct packed {
        logic [N-1:0] conv;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] a;
    logic         signbit;
    logic         out_valid;
    logic [N-1:0] converted;
    logic         ovf;

    exp_t         exp_q[$];
    int           n_checks;
    int           n_fail;
    logic         started;
    logic         rst_q;
    logic         vld_q;
    logic [N-1:0] hold_conv;
    logic         hold_ovf;

    convert_to_twos_comp #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .signbit   (signbit),
        .out_valid (out_valid),
        .converted (converted),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed value, range test and optional clamp, then keep the low N bits.
    function automatic exp_t model(input logic [N-1:0] av, input logic s);
        longint v;
        longint hi;
        longint lo;
        exp_t   e;
        v  = s ? -longint'(av) : longint'(av);
        hi = (longint'(1) <<< (N - 1)) - 1;
        lo = -(longint'(1) <<< (N - 1));
        e.o = (v > hi) || (v < lo);
`ifdef CONVERT_TO_TWOS_COMP_SAT_EN
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
`endif
        e.conv = v[N-1:0];
        return e;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [N-1:0] av, input logic s);
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        a        = av;
        signbit  = s;
        if (v && !r) exp_q.push_back(model(av, s));
    endtask

    // What the bench itself drove at the last edge.
    always @(posedge clk) begin
        started <= 1'b1;
        rst_q   <= rst;
        vld_q   <= in_valid && !rst;
    end

    // Monitor: compare valid, pop results, and check hold / reset values otherwise.
    always @(negedge clk) begin
        if (started) begin
            exp_t e;
            n_checks++;
            if (out_valid !== vld_q) begin
                n_fail++;
                $display("FAIL out_valid: got %b expected %b at %0t", out_valid, vld_q, $time);
            end
            if (rst_q) begin
                hold_conv = '0;
                hold_ovf  = 1'b0;
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got %b/%b expected no output at %0t", converted, ovf, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (converted !== e.conv || ovf !== e.o) begin
                        n_fail++;
                        $display("FAIL result: got conv=%b ovf=%b expected conv=%b ovf=%b at %0t",
                                 converted, ovf, e.conv, e.o, $time);
                    end
                    hold_conv = e.conv;
                    hold_ovf  = e.o;
                end
            end else begin
                n_checks++;
                if (converted !== hold_conv || ovf !== hold_ovf) begin
                    n_fail++;
                    $display("FAIL hold: got conv=%b ovf=%b expected conv=%b ovf=%b at %0t",
                             converted, ovf, hold_conv, hold_ovf, $time);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] bnd[5];
        logic [N-1:0] av;
        n_checks  = 0;
        n_fail    = 0;
        started   = 1'b0;
        rst_q     = 1'b1;
        vld_q     = 1'b0;
        hold_conv = '0;
        hold_ovf  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        signbit   = 1'b0;
        bnd[0] = 10'b0000000000;
        bnd[1] = 10'b1000000000;
        bnd[2] = 10'b0111111111;
        bnd[3] = 10'b1000000001;
        bnd[4] = 10'b1111111111;

        drive(1'b1, 1'b1, 10'b0101010101, 1'b1);
        drive(1'b1, 1'b0, 10'b0, 1'b0);
        drive(1'b0, 1'b1, 10'b0110110101, 1'b0);
        drive(1'b0, 1'b1, 10'b0110110101, 1'b1);
        drive(1'b0, 1'b1, 10'b0000000000, 1'b1);
        drive(1'b0, 1'b1, 10'b1000000000, 1'b1);
        drive(1'b0, 1'b0, 10'b0011001100, 1'b0);
        drive(1'b0, 1'b1, 10'b1111111111, 1'b1);
        drive(1'b0, 1'b1, 10'b1000000000, 1'b0);
        drive(1'b0, 1'b0, 10'b0, 1'b0);
        drive(1'b0, 1'b0, 10'b0, 1'b0);
        // Reset pulsed on the middle of three back-to-back inputs.
        drive(1'b0, 1'b1, 10'b0000000111, 1'b1);
        drive(1'b1, 1'b1, 10'b0000001111, 1'b0);
        drive(1'b0, 1'b1, 10'b0000011111, 1'b1);
        drive(1'b0, 1'b0, 10'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) av = bnd[$urandom_range(0, 4)];
            else av = N'($urandom_range(0, 1023));
            drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), av, 1'($urandom_range(0, 1)));
        end

        drive(1'b0, 1'b0, 10'b0, 1'b0);
        drive(1'b0, 1'b0, 10'b0, 1'b0);
        drive(1'b0, 1'b0, 10'b0, 1'b0);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/convert_to_twos_comp.md
CONVERT_TO_TWOS_COMP -- requirements
Module: convert_to_twos_comp

Interface
REQ-001 Parameter N, default 10: width of the magnitude input and of the converted output; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  qualifies a and signbit for sampling on the current clock edge.
REQ-005 a  input  N  unsigned magnitude to convert.
REQ-006 signbit  input  1  sign of the value (0 = positive, 1 = negative).
REQ-007 out_valid  output  1  converted and ovf hold a new result.
REQ-008 converted  output  N  two's-complement encoding of the signed value.
REQ-009 ovf  output  1  the signed value does not fit in N-bit two's complement.

Function
REQ-010 Conversion rule:
- signbit=0: the raw result SHALL be a.
- signbit=1: the raw result SHALL be (~a)+1, truncated to N bits (modulo 2^N).
REQ-011 Latency and output registers:
- Result SHALL appear exactly one clock after the edge at which in_valid=1 is sampled.
- converted and ovf SHALL be registered outputs, with no combinational path from inputs.
REQ-012 out_valid SHALL equal in_valid delayed by one clock.
- There is no backpressure; a new input SHALL be accepted on every clock in which in_valid=1.
REQ-013 When in_valid=0, converted and ovf SHALL hold their previous values and out_valid SHALL be 0 on the next clock.
REQ-014 Overflow is defined as:
- signbit=0 and a >= 2^(N-1); or
- signbit=1 and a > 2^(N-1).
REQ-015 Boundary values:
- a=0 with signbit=1 SHALL give converted=0 and ovf=0 (no negative zero).
- a=2^(N-1) with signbit=1 SHALL give converted = 1 followed by N-1 zeros, with ovf=0.
REQ-016 Back-to-back inputs on consecutive clocks SHALL each produce their own result on consecutive clocks, with no loss or duplication.
REQ-017 All arithmetic SHALL be performed at N bits; carries out of bit N-1 are discarded.

Reset
REQ-018 While rst=1 at a clock edge, the next outputs SHALL be out_valid=0, converted=0 and ovf=0, and any input sampled on that edge SHALL be discarded.
REQ-019 If rst is asserted while a result is in flight, that result SHALL be dropped.
- The first valid result after reset deasserts SHALL come from the first in_valid=1 sampled with rst=0.

Configuration
REQ-020 Macro CONVERT_TO_TWOS_COMP_SAT_EN SHALL select the overflow handling.
- Defined: on overflow, converted SHALL saturate to 2^(N-1)-1 for signbit=0 and to -2^(N-1) for signbit=1, and ovf SHALL follow REQ-014.
- Undefined: converted SHALL always be the raw wrapped result of REQ-010, and ovf SHALL still be reported per REQ-014.
- Non-overflow results SHALL be identical in both builds.

Verification
REQ-021 The bench SHALL cover these directed scenarios (N=10):
- a=0110110101, signbit=0, in_valid=1 -> next clock: converted=0110110101, ovf=0, out_valid=1.
- a=0110110101, signbit=1 -> next clock: converted=1001001011, ovf=0.
- a=0000000000, signbit=1 -> converted=0000000000, ovf=0; then a=1000000000, signbit=1 -> converted=1000000000, ovf=0.
- a=1111111111, signbit=1 -> ovf=1; converted=0000000001 without the macro, 1000000000 with it.
- a=1000000000, signbit=0 -> ovf=1; converted=1000000000 without the macro, 0111111111 with it.
- Three inputs on consecutive clocks with rst pulsed on the second -> first result appears, second is dropped with out_valid=0 and outputs zero, third appears normally.
